// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and per-stage payload widths.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY,
      PS_ONE,
      PS_TWO
   } pipe_state_t;

   // fetch/decode: 32-bit instruction + 64-bit PC
   localparam int IF_ID_W = 96;
   // decode/execute: two 64-bit operands, 32-bit instruction, 8-bit control
   localparam int ID_EX_W = 168;

   function automatic logic [1:0] state_occupancy(input pipe_state_t s);
      logic [1:0] occ;
      case (s)
         PS_ONE:  occ = 2'd1;
         PS_TWO:  occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional two-entry
// skid buffer and synchronous flush.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// PS_EMPTY | nothing held, out_valid low
// PS_ONE   | main entry holds a word presented on out_data
// PS_TWO   | main and skid entries both hold words (SKID != 0 only)
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = IF_ID_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter int                SKID      = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   pipe_state_t       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_fire;

   // Next-state and entry loads; flush wipes both entries regardless of handshakes.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      in_fire = in_valid && in_ready;
      if (flush) begin
         state_d = PS_EMPTY;
         main_d  = RESET_VAL;
         skid_d  = RESET_VAL;
      end else begin
         case (state_q)
            PS_EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = PS_ONE;
               end
            end
            PS_ONE: begin
               if (in_fire && out_ready) begin
                  main_d = in_data;
               end else if (in_fire && (SKID != 0)) begin
                  skid_d  = in_data;
                  state_d = PS_TWO;
               end else if (out_ready) begin
                  // main keeps its stale value; out_valid masks it
                  state_d = PS_EMPTY;
               end
            end
            PS_TWO: begin
               if (out_ready) begin
                  main_d  = skid_q;
                  state_d = PS_ONE;
               end
            end
            default: state_d = PS_EMPTY;
         endcase
      end
   end

   // State and entry registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= PS_EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic in_ready_q, in_ready_d;

         // Registered ready: precomputed from the next state so it never waits on out_ready.
         always_comb begin
            in_ready_d = (state_d != PS_TWO);
         end

         // Resets high so the stage accepts on the first cycle out of reset.
         always_ff @(posedge clk) begin
            if (reset) begin
               in_ready_q <= 1'b1;
            end else begin
               in_ready_q <= in_ready_d;
            end
         end

         assign in_ready = in_ready_q && !reset;
      end else begin : g_noskid
         assign in_ready = (out_ready || (state_q == PS_EMPTY)) && !reset;
      end
   endgenerate

   assign out_valid = (state_q != PS_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_occupancy(state_q);

endmodule
